// File: rtl/lcd_pkg.sv
// ============================================================================
// Module      : lcd_pkg
// Description : Shared HD44780 bus constants, FSM encoding and address helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam logic [7:0] LCD_CLR   = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;
    localparam logic [7:0] LCD_ENTRY = 8'h04;
    localparam logic [7:0] LCD_DISP  = 8'h08;
    localparam logic [7:0] LCD_SHIFT = 8'h10;
    localparam logic [7:0] LCD_FUNC  = 8'h20;
    localparam logic [7:0] LCD_CGRAM = 8'h40;
    localparam logic [7:0] LCD_DDRAM = 8'h80;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam int         NUM_CELLS  = 2 * LINE_LEN;
    localparam logic [7:0] SPACE      = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } clr_state_e;

    // Next address counter value; line ends wrap onto the other line.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] l1_last;
        logic [6:0] l2_last;
        logic [6:0] nxt;
        l1_last = LINE1_BASE + 7'(LINE_LEN - 1);
        l2_last = LINE2_BASE + 7'(LINE_LEN - 1);
        if (inc) begin
            if (a == l1_last)      nxt = LINE2_BASE;
            else if (a == l2_last) nxt = LINE1_BASE;
            else                   nxt = a + 7'd1;
        end else begin
            if (a == LINE2_BASE)      nxt = l1_last;
            else if (a == LINE1_BASE) nxt = l2_last;
            else                      nxt = a - 7'd1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_ddram_shadow.sv
// ============================================================================
// Module      : lcd_ddram_shadow
// Description : 32x8 DDRAM shadow, one synchronous write port, two async reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ddram_shadow
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [4:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] mem_q [NUM_CELLS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                mem_q[i] <= SPACE;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
// ============================================================================
// Module      : lcd_bus_receiver
// Description : HD44780-style bus responder with DDRAM shadow and busy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_receiver #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E_in,
    input  logic       RW_in,
    input  logic       RS_in,
    input  logic [7:0] DB_in,
    output logic [7:0] DB_rd,
    output logic       busy,
    output logic       display_on,
    output logic [6:0] addr,
    output logic       wr_strobe,
    output logic [4:0] wr_idx,
    output logic [7:0] wr_char,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic       proto_err
);

    import lcd_pkg::*;

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] C_CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
    localparam logic [4:0]       C_LAST_CELL  = 5'(NUM_CELLS - 1);

    logic             e_q;
    logic [6:0]       addr_q,      addr_d;
    logic             inc_q,       inc_d;
    logic             disp_q,      disp_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             proto_err_q, proto_err_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [4:0]       wr_idx_q,    wr_idx_d;
    logic [7:0]       wr_char_q,   wr_char_d;
    clr_state_e       state_q,     state_d;
    logic [4:0]       clr_idx_q,   clr_idx_d;

    logic       fall;
    logic [4:0] cur_idx;
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [7:0] cur_char;

    assign fall    = e_q & ~E_in;
    assign cur_idx = {addr_q[6], addr_q[3:0]};

    lcd_ddram_shadow u_shadow (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (cur_idx),
        .rdata_a (cur_char),
        .raddr_b (rd_idx),
        .rdata_b (rd_char)
    );

    always_comb begin
        addr_d      = addr_q;
        inc_d       = inc_q;
        disp_d      = disp_q;
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q;
        wr_strobe_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_char_d   = wr_char_q;
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        mem_we      = 1'b0;
        mem_waddr   = clr_idx_q;
        mem_wdata   = SPACE;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (state_q == ST_CLEARING) begin
            mem_we = 1'b1;
            if (clr_idx_q == C_LAST_CELL) begin
                state_d = ST_IDLE;
            end else begin
                clr_idx_d = clr_idx_q + 5'd1;
            end
        end

        // Busy is judged on the registered counter, never on the reload.
        if (fall) begin
            if (RW_in) begin
                if (RS_in) begin
                    addr_d = addr_step(addr_q, inc_q);
                end
            end else if (cnt_q != '0) begin
                proto_err_d = 1'b1;
            end else if (RS_in) begin
                mem_we      = 1'b1;
                mem_waddr   = cur_idx;
                mem_wdata   = DB_in;
                wr_strobe_d = 1'b1;
                wr_idx_d    = cur_idx;
                wr_char_d   = DB_in;
                addr_d      = addr_step(addr_q, inc_q);
                cnt_d       = C_BUSY_LOAD;
            end else if ((DB_in & LCD_DDRAM) != 8'h00) begin
                cnt_d = C_BUSY_LOAD;
                if (DB_in[5:4] == 2'b00) begin
                    addr_d = DB_in[6:0];
                end else begin
                    proto_err_d = 1'b1;
                end
            end else if ((DB_in & (LCD_CGRAM | LCD_FUNC | LCD_SHIFT)) != 8'h00) begin
                cnt_d = C_BUSY_LOAD;
            end else if ((DB_in & LCD_DISP) != 8'h00) begin
                disp_d = DB_in[2];
                cnt_d  = C_BUSY_LOAD;
            end else if ((DB_in & LCD_ENTRY) != 8'h00) begin
                inc_d = DB_in[1];
                cnt_d = C_BUSY_LOAD;
            end else if ((DB_in & LCD_HOME) != 8'h00) begin
                addr_d = LINE1_BASE;
                cnt_d  = C_BUSY_LOAD;
            end else if ((DB_in & LCD_CLR) != 8'h00) begin
                addr_d    = LINE1_BASE;
                inc_d     = 1'b1;
                cnt_d     = C_CLEAR_LOAD;
                state_d   = ST_CLEARING;
                clr_idx_d = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= 1'b0;
            addr_q      <= LINE1_BASE;
            inc_q       <= 1'b1;
            disp_q      <= 1'b0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= 5'd0;
            wr_char_q   <= 8'h00;
            state_q     <= ST_IDLE;
            clr_idx_q   <= 5'd0;
        end else begin
            e_q         <= E_in;
            addr_q      <= addr_d;
            inc_q       <= inc_d;
            disp_q      <= disp_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            wr_strobe_q <= wr_strobe_d;
            wr_idx_q    <= wr_idx_d;
            wr_char_q   <= wr_char_d;
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
        end
    end

    assign busy       = (cnt_q != '0);
    assign display_on = disp_q;
    assign addr       = addr_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_idx     = wr_idx_q;
    assign wr_char    = wr_char_q;
    assign proto_err  = proto_err_q;
    assign DB_rd      = (E_in && RW_in && !reset) ? (RS_in ? cur_char : {busy, addr_q}) : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
// ============================================================================
// Module      : tb_lcd_bus_receiver
// Description : Self-checking bench for lcd_bus_receiver with write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/10ps

module tb_lcd_bus_receiver;

    localparam int BUSY_CYCLES  = 40;
    localparam int CLEAR_CYCLES = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       E_in, RW_in, RS_in;
    logic [7:0] DB_in;
    logic [7:0] DB_rd;
    logic       busy, display_on, wr_strobe, proto_err;
    logic [6:0] addr;
    logic [4:0] wr_idx, rd_idx;
    logic [7:0] wr_char, rd_char;

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] ch;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    wr_exp_t mon_e;
    int checks = 0;
    int errors = 0;

    lcd_bus_receiver #(
        .BUSY_CYCLES  (BUSY_CYCLES),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .E_in       (E_in),
        .RW_in      (RW_in),
        .RS_in      (RS_in),
        .DB_in      (DB_in),
        .DB_rd      (DB_rd),
        .busy       (busy),
        .display_on (display_on),
        .addr       (addr),
        .wr_strobe  (wr_strobe),
        .wr_idx     (wr_idx),
        .wr_char    (wr_char),
        .rd_idx     (rd_idx),
        .rd_char    (rd_char),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // Every data-write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && wr_strobe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_strobe_unexpected: got idx=%0d char=%h, required no pulse", wr_idx, wr_char);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_idx !== mon_e.idx || wr_char !== mon_e.ch) begin
                    errors++;
                    $display("FAIL wr_strobe_data: got idx=%0d char=%h, required idx=%0d char=%h",
                             wr_idx, wr_char, mon_e.idx, mon_e.ch);
                end
            end
        end
    end

    task automatic bus_cycle(input logic rw, input logic rs, input logic [7:0] db);
        @(negedge clk);
        RW_in = rw; RS_in = rs; DB_in = db; E_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        E_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_data(input logic [7:0] ch, input logic [4:0] idx);
        exp_q.push_back('{idx: idx, ch: ch});
        bus_cycle(1'b0, 1'b1, ch);
    endtask

    task automatic measure_busy(input string name, input int exp_n);
        int n = 0;
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL %s: busy cycles got %0d, required %0d", name, n, exp_n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: busy got %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic check_all_blank(input string name);
        int bad = 0;
        logic [7:0] first_bad = 8'h20;
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            #0.1;
            if (rd_char !== 8'h20) begin
                if (bad == 0) first_bad = rd_char;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d non-blank cells (first got %h), required all 20", name, bad, first_bad);
        end
    endtask

    task automatic check_cell(input string name, input logic [4:0] idx, input logic [7:0] exp_ch);
        rd_idx = idx;
        #0.1;
        checks++;
        if (rd_char !== exp_ch) begin
            errors++;
            $display("FAIL %s: cell %0d got %h, required %h", name, idx, rd_char, exp_ch);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_all_blank("reset_cells");
        checks++;
        if ({addr, busy, display_on, proto_err, wr_strobe} !== 11'b0 || DB_rd !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got addr=%h busy=%b disp=%b err=%b strobe=%b dbrd=%h, required all 0",
                     addr, busy, display_on, proto_err, wr_strobe, DB_rd);
        end
    endtask

    task automatic test_display();
        bus_cycle(1'b0, 1'b0, 8'h0C);
        measure_busy("busy_after_disp_ctrl", BUSY_CYCLES);
        checks++;
        if (display_on !== 1'b1) begin
            errors++;
            $display("FAIL display_on: got %b, required 1", display_on);
        end
        bus_cycle(1'b0, 1'b0, 8'h06);
        measure_busy("busy_after_entry_mode", BUSY_CYCLES);
    endtask

    task automatic test_data_write();
        bus_cycle(1'b0, 1'b0, 8'h8E);
        wait_idle();
        checks++;
        if (addr !== 7'h0E) begin
            errors++;
            $display("FAIL set_addr_0e: got %h, required 0e", addr);
        end
        write_data(8'h31, 5'd14); wait_idle();
        write_data(8'h32, 5'd15); wait_idle();
        write_data(8'h33, 5'd16); wait_idle();
        checks++;
        if (addr !== 7'h41) begin
            errors++;
            $display("FAIL addr_line_wrap: got %h, required 41", addr);
        end
        check_cell("cell14", 5'd14, 8'h31);
        check_cell("cell15", 5'd15, 8'h32);
        check_cell("cell16", 5'd16, 8'h33);
    endtask

    task automatic test_decrement_read();
        bus_cycle(1'b0, 1'b0, 8'h04); wait_idle();
        bus_cycle(1'b0, 1'b0, 8'h80); wait_idle();
        write_data(8'h41, 5'd0);
        @(negedge clk);
        RW_in = 1'b1; RS_in = 1'b0; E_in = 1'b1;
        @(negedge clk);
        checks++;
        if (DB_rd !== 8'hCF) begin
            errors++;
            $display("FAIL bf_addr_read: got %h, required cf", DB_rd);
        end
        E_in = 1'b0;
        @(negedge clk);
        checks++;
        if (addr !== 7'h4F || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL instr_read_side_effect: got addr=%h err=%b, required addr=4f err=0", addr, proto_err);
        end
        check_cell("cell0_A", 5'd0, 8'h41);
        // Data read at 0x4F (cell 31, blank) then decrement to 0x4E.
        @(negedge clk);
        RS_in = 1'b1; E_in = 1'b1;
        @(negedge clk);
        checks++;
        if (DB_rd !== 8'h20) begin
            errors++;
            $display("FAIL data_read: got %h, required 20", DB_rd);
        end
        E_in = 1'b0;
        @(negedge clk);
        checks++;
        if (addr !== 7'h4E) begin
            errors++;
            $display("FAIL data_read_step: got addr=%h, required 4e", addr);
        end
        wait_idle();
        bus_cycle(1'b0, 1'b0, 8'h06); wait_idle();
    endtask

    task automatic test_clear();
        int n = 0;
        bus_cycle(1'b0, 1'b0, 8'h01);
        while (busy === 1'b1 && n < 500) begin
            n++;
            if (n == 33) check_all_blank("clear_fill_by_33");
            @(negedge clk);
        end
        checks++;
        if (n !== CLEAR_CYCLES || addr !== 7'h00) begin
            errors++;
            $display("FAIL clear_busy: got %0d cycles addr=%h, required %0d addr=00", n, addr, CLEAR_CYCLES);
        end
    endtask

    task automatic test_write_while_busy();
        write_data(8'h55, 5'd0); wait_idle();
        bus_cycle(1'b0, 1'b0, 8'h01);
        repeat (5) @(negedge clk);
        bus_cycle(1'b0, 1'b1, 8'h66);
        checks++;
        if (proto_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_while_clearing: got err=%b busy=%b, required err=1 busy=1", proto_err, busy);
        end
        measure_busy("busy_not_reloaded", CLEAR_CYCLES - 9);
        check_cell("cell0_cleared", 5'd0, 8'h20);
        checks++;
        if (addr !== 7'h00) begin
            errors++;
            $display("FAIL addr_after_ignored: got %h, required 00", addr);
        end
    endtask

    task automatic test_bad_addr();
        apply_reset();
        bus_cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (busy !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL nop_instr: got busy=%b err=%b, required 0 0", busy, proto_err);
        end
        bus_cycle(1'b0, 1'b0, 8'h85); wait_idle();
        write_data(8'h5A, 5'd5); wait_idle();
        bus_cycle(1'b0, 1'b0, 8'hA0);
        checks++;
        if (addr !== 7'h06 || proto_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bad_ddram_addr: got addr=%h err=%b busy=%b, required addr=06 err=1 busy=1",
                     addr, proto_err, busy);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b0 || busy !== 1'b0 || addr !== 7'h00 || display_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy: got err=%b busy=%b addr=%h disp=%b, required 0 0 00 0",
                     proto_err, busy, addr, display_on);
        end
        check_all_blank("reset_mid_busy_cells");
    endtask

    initial begin
        reset = 1'b1;
        E_in = 1'b0; RW_in = 1'b0; RS_in = 1'b0; DB_in = 8'h00; rd_idx = 5'd0;
        test_reset();
        test_display();
        test_data_write();
        test_decrement_read();
        test_clear();
        test_write_while_busy();
        test_bad_addr();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Synthesizable HD44780-style responder: the receiving end of the E/RW/RS/DB bus our LCD driver generates.
- Decodes commands and data writes, maintains a 2x16 DDRAM shadow, and models the busy flag and busy-flag/address reads.
- Used in benches as the self-checking LCD model; also usable on-chip as a display mirror for debug readout.

Parameters:
- BUSY_CYCLES, 40, clk cycles busy after any accepted write other than clear (1..255).
- CLEAR_CYCLES, 64, clk cycles busy after clear display; must be >= 32.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- E_in  in  1  LCD enable strobe; a transaction is taken on its falling edge.
- RW_in  in  1  1 = read, 0 = write.
- RS_in  in  1  0 = instruction, 1 = data.
- DB_in  in  8  write data bus.
- DB_rd  out  8  read data; valid while E_in=1 and RW_in=1.
- busy  out  1  internal busy flag.
- display_on  out  1  display on/off control bit D.
- addr  out  7  current DDRAM address (AC).
- wr_strobe  out  1  one-cycle pulse on each accepted data write.
- wr_idx  out  5  linear cell index of that write: line1 = 0-15, line2 = 16-31.
- wr_char  out  8  character written.
- rd_idx  in  5  debug readback index.
- rd_char  out  8  DDRAM[rd_idx]; combinational.
- proto_err  out  1  sticky: write while busy, or illegal DDRAM address.

Behaviour:
- Reset values: all 32 cells = 0x20, addr = 0x00, inc = 1, display_on = 0, busy = 0, busy counter = 0, proto_err = 0, wr_strobe = 0, DB_rd = 0x00.
- Edge detection: E_in is registered as e_q; a falling edge is e_q=1 and E_in=0. RW_in, RS_in and DB_in are sampled in that same cycle. Effects are visible on the next clk edge, so latency is 1 cycle.
- Busy counter: loaded on each accepted write, decrements to 0; busy = (counter != 0).
- Write while busy: transaction ignored, proto_err set, counter not reloaded.
- Instruction decode (RS=0, RW=0), highest set bit wins:
  - 0x80|a, set DDRAM address: a in 0x00-0x0F or 0x40-0x4F sets addr = a. Any other a leaves addr unchanged and sets proto_err; the busy counter still loads.
  - 0x40-0x7F, CGRAM address: accepted as a no-op, busy loads.
  - 0x20-0x3F, function set: accepted as a no-op, busy loads.
  - 0x10-0x1F, cursor/display shift: accepted as a no-op, busy loads.
  - 0x08-0x0F, display control: display_on = DB[2].
  - 0x04-0x07, entry mode: inc = DB[1]; DB[0] (shift) is ignored.
  - 0x02-0x03, return home: addr = 0.
  - 0x01, clear: addr = 0, inc = 1, busy = CLEAR_CYCLES. A clear FSM in CLEARING state writes 0x20 to cells 0..31, one per cycle, then returns to IDLE.
  - 0x00: ignored; no busy, no error.
- Data write (RS=1, RW=0):
  - Writes DDRAM[idx(addr)] = DB_in and pulses wr_strobe with wr_idx/wr_char.
  - Then addr steps by the inc direction with these wraps: 0x0F->0x40, 0x4F->0x00 when incrementing; 0x40->0x0F, 0x00->0x4F when decrementing.
- Index mapping: idx = addr[6] ? 16 + addr[3:0] : addr[3:0].
- Read (RW=1):
  - While E_in=1, DB_rd = RS ? DDRAM[idx(addr)] : {busy, addr}. DB_rd is 0x00 when not reading.
  - A falling edge of a data read advances addr exactly as a write does. Instruction reads do not change addr.
  - Reads are allowed while busy and never set proto_err.
- FSM states: IDLE, CLEARING.
  - Transactions are handled only in IDLE or CLEARING.
  - While CLEARING, busy=1, so writes are error-ignored.
  - wr_strobe is not pulsed for clear fills.
- Simultaneous events: a falling edge in the same cycle the counter reaches 0 sees busy=0 only if the counter was already 0 in the previous cycle. The busy decision uses the registered value.
- Synchronous reset mid-clear or mid-busy immediately restores all reset values, and the FSM goes to IDLE.

Decomposition:
- Shared package lcd_pkg holds:
  - instruction opcode masks (LCD_CLR, LCD_HOME, LCD_ENTRY, LCD_DISP, LCD_SHIFT, LCD_FUNC, LCD_CGRAM, LCD_DDRAM);
  - line base addresses 0x00/0x40, LINE_LEN = 16, SPACE = 0x20;
  - FSM state encoding.
- The driver side reuses the same constants.
- One sub-module is natural: lcd_ddram_shadow, a 32x8 register file with one sync write port and two async read ports (DB_rd path and rd_char path).

Test Plan:
- Reset, then clk idle 10 cycles -> rd_char = 0x20 at every idx 0..31, addr = 0, busy = 0, display_on = 0, proto_err = 0.
- Write instr 0x0C, wait BUSY_CYCLES, then instr 0x06 -> display_on = 1, inc = 1, busy high for exactly 40 cycles after each falling edge.
- Set addr 0x80 | 0x0E, data 0x31, 0x32, 0x33 (each after busy clears) -> cells 14 = '1', 15 = '2', 16 = '3'; addr = 0x41; three wr_strobe pulses with wr_idx 14, 15, 16.
- Entry mode 0x04 (decrement), set addr 0x00, data 0x41 -> cell 0 = 'A', addr = 0x4F. Then a read with RS=0, E=1 during busy -> DB_rd = 0xCF.
- Write 0x01 with cells non-blank -> busy for 64 cycles, all cells 0x20 by cycle 33, addr = 0. A data write at cycle 10 is ignored and sets proto_err.
- Set addr 0x80 | 0x20 -> addr unchanged, proto_err = 1. Then assert reset mid-busy for 1 cycle -> proto_err = 0, busy = 0, cells 0x20.
